// File: rtl/field_compositor.sv
// Sequential piece compositor: copies the locked field, overlays the rotated piece one cell per cycle, then publishes the frame.
// Build option: define COLLISION_EN to build the collision / out-of-bounds flag logic; otherwise both outputs are tied low.
module field_compositor #(
  parameter int FIELD_W = 20,
  parameter int FIELD_H = 20,
  parameter int PIECE_N = 4,
  parameter int COORD_W = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         start,
  input  logic [FIELD_W*FIELD_H-1:0]   locked_field,
  input  logic [COORD_W-1:0]           block_pos_x,
  input  logic [COORD_W-1:0]           block_pos_y,
  input  logic [PIECE_N*PIECE_N-1:0]   block_matrix,
  input  logic [1:0]                   rotate,
  output logic [FIELD_W*FIELD_H-1:0]   field_display,
  output logic                         busy,
  output logic                         done,
  output logic                         collision,
  output logic                         out_of_bounds
);

  localparam int CELLS  = FIELD_W * FIELD_H;
  localparam int NN     = PIECE_N * PIECE_N;
  localparam int M      = PIECE_N - 1;
  localparam int IDX_W  = (NN > 1) ? $clog2(NN) : 1;
  localparam int CELL_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_COMMIT} state_e;

  state_e               state_q;
  logic [CELLS-1:0]     scratch_q;
  logic [CELLS-1:0]     display_q;
  logic [IDX_W-1:0]     idx_q;
  logic [COORD_W-1:0]   posx_q;
  logic [COORD_W-1:0]   posy_q;
  logic [NN-1:0]        mat_q;
  logic [1:0]           rot_q;
  logic                 busy_q;
  logic                 done_q;

  int unsigned          row_d;
  int unsigned          col_d;
  logic [IDX_W-1:0]     src_idx_d;
  logic                 src_bit_d;
  logic [COORD_W:0]     tx_d;
  logic [COORD_W:0]     ty_d;
  logic                 valid_d;
  logic [CELL_W-1:0]    cell_addr_d;
  logic                 write_d;

  // Map the current destination cell (row, col) back to its source bit in the unrotated matrix.
  always_comb begin
    row_d     = 32'(idx_q) / PIECE_N;
    col_d     = 32'(idx_q) % PIECE_N;
    src_idx_d = '0;
    unique case (rot_q)
      2'd0: src_idx_d = IDX_W'(row_d * PIECE_N + col_d);
      2'd1: src_idx_d = IDX_W'((M - col_d) * PIECE_N + row_d);
      2'd2: src_idx_d = IDX_W'((M - row_d) * PIECE_N + (M - col_d));
      2'd3: src_idx_d = IDX_W'(col_d * PIECE_N + (M - row_d));
    endcase
    src_bit_d   = mat_q[src_idx_d];
    tx_d        = (COORD_W+1)'(32'(posx_q) + col_d);
    ty_d        = (COORD_W+1)'(32'(posy_q) + row_d);
    valid_d     = (32'(tx_d) < 32'(FIELD_W)) && (32'(ty_d) < 32'(FIELD_H));
    cell_addr_d = CELL_W'(32'(ty_d) * 32'(FIELD_W) + 32'(tx_d));
    write_d     = src_bit_d && valid_d;
  end

`ifdef COLLISION_EN
  logic coll_flag_q;
  logic oob_flag_q;
  logic coll_q;
  logic oob_q;
  logic hit_d;
  logic miss_d;

  always_comb begin
    hit_d  = write_d && scratch_q[cell_addr_d];
    miss_d = src_bit_d && !valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coll_flag_q <= 1'b0;
      oob_flag_q  <= 1'b0;
      coll_q      <= 1'b0;
      oob_q       <= 1'b0;
    end else if (en) begin
      case (state_q)
        S_LOAD: begin
          coll_flag_q <= 1'b0;
          oob_flag_q  <= 1'b0;
        end
        S_DRAW: begin
          if (hit_d)  coll_flag_q <= 1'b1;
          if (miss_d) oob_flag_q  <= 1'b1;
        end
        S_COMMIT: begin
          coll_q <= coll_flag_q;
          oob_q  <= oob_flag_q;
        end
        default: ;
      endcase
    end
  end

  assign collision     = coll_q;
  assign out_of_bounds = oob_q;
`else
  assign collision     = 1'b0;
  assign out_of_bounds = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      scratch_q <= '0;
      display_q <= '0;
      idx_q     <= '0;
      posx_q    <= '0;
      posy_q    <= '0;
      mat_q     <= '0;
      rot_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            posx_q  <= block_pos_x;
            posy_q  <= block_pos_y;
            mat_q   <= block_matrix;
            rot_q   <= rotate;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          scratch_q <= locked_field;
          idx_q     <= '0;
          state_q   <= S_DRAW;
        end
        S_DRAW: begin
          // Piece cells only ever set bits, so locked cells survive under empty piece cells.
          if (write_d) scratch_q[cell_addr_d] <= 1'b1;
          if (idx_q == IDX_W'(NN - 1)) state_q <= S_COMMIT;
          else                         idx_q   <= idx_q + IDX_W'(1);
        end
        S_COMMIT: begin
          display_q <= scratch_q;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign field_display = display_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_field_compositor.sv
// Self-checking bench for field_compositor: directed scenarios plus randomized frames against a grid-rotation model.
module tb_field_compositor;

  localparam int FW = 20;
  localparam int FH = 20;
  localparam int CELLS = FW * FH;
  localparam int LAT = 18;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               start;
  logic [CELLS-1:0]   locked_field;
  logic [4:0]         block_pos_x;
  logic [4:0]         block_pos_y;
  logic [15:0]        block_matrix;
  logic [1:0]         rotate;
  logic [CELLS-1:0]   field_display;
  logic               busy;
  logic               done;
  logic               collision;
  logic               out_of_bounds;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  field_compositor dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start),
    .locked_field(locked_field), .block_pos_x(block_pos_x), .block_pos_y(block_pos_y),
    .block_matrix(block_matrix), .rotate(rotate),
    .field_display(field_display), .busy(busy), .done(done),
    .collision(collision), .out_of_bounds(out_of_bounds)
  );

  // Reference: rotate the piece as a 2-D grid by repeated 90-degree clockwise turns, then stamp it.
  task automatic model(input logic [CELLS-1:0] lf, input int px, input int py,
                       input logic [15:0] m, input int rot,
                       output logic [CELLS-1:0] fd, output logic c, output logic o);
    logic g [4][4];
    logic t [4][4];
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++) g[r][cc] = m[r*4+cc];
    for (int k = 0; k < rot; k++) begin
      for (int r = 0; r < 4; r++)
        for (int cc = 0; cc < 4; cc++) t[r][cc] = g[3-cc][r];
      g = t;
    end
    fd = lf; c = 1'b0; o = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (g[r][cc]) begin
          if (px + cc < FW && py + r < FH) begin
            if (lf[(py+r)*FW + px + cc]) c = 1'b1;
            fd[(py+r)*FW + px + cc] = 1'b1;
          end else o = 1'b1;
        end
`ifndef COLLISION_EN
    c = 1'b0; o = 1'b0;
`endif
  endtask

  task automatic launch(input logic [CELLS-1:0] lf, input int px, input int py,
                        input logic [15:0] m, input int rot);
    locked_field = lf;
    block_pos_x  = px[4:0];
    block_pos_y  = py[4:0];
    block_matrix = m;
    rotate       = rot[1:0];
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_frame(input logic [CELLS-1:0] lf, input int px, input int py,
                           input logic [15:0] m, input int rot, output int lat);
    launch(lf, px, py, m, rot);
    wait_done(lat);
  endtask

  task automatic test_reset();
    int lat;
    run_frame('0, 3, 3, 16'h0033, 0, lat);
    launch('0, 1, 1, 16'hFFFF, 1);
    repeat (5) begin @(posedge clk); #1; end
    en = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1;
    checks++;
    if (field_display !== '0) begin errors++; $display("FAIL reset_display got %h exp 0", field_display); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || collision !== 1'b0 || out_of_bounds !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b done=%b coll=%b oob=%b exp all 0", busy, done, collision, out_of_bounds);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done); end
    $display("test_reset: partial frame discarded");
  endtask

  task automatic test_latency();
    int lat;
    logic [CELLS-1:0] exp_fd;
    launch('0, 0, 0, 16'h000F, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b exp 1", busy); end
    wait_done(lat);
    exp_fd = '0; exp_fd[3:0] = 4'hF;
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL latency got %0d exp %0d", lat, LAT); end
    checks++;
    if (field_display !== exp_fd) begin errors++; $display("FAIL latency_frame got %h exp %h", field_display, exp_fd); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b exp 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", done); end
    $display("test_latency: lat=%0d", lat);
  endtask

  task automatic test_rotation();
    int lat;
    logic [CELLS-1:0] exp_fd;
    run_frame('0, 5, 5, 16'h000F, 1, lat);
    exp_fd = '0;
    exp_fd[5*20+8] = 1'b1; exp_fd[6*20+8] = 1'b1; exp_fd[7*20+8] = 1'b1; exp_fd[8*20+8] = 1'b1;
    checks++;
    if (field_display !== exp_fd) begin errors++; $display("FAIL rot90 got %h exp %h", field_display, exp_fd); end
    run_frame('0, 5, 5, 16'h000F, 2, lat);
    exp_fd = '0;
    for (int x = 5; x <= 8; x++) exp_fd[8*20+x] = 1'b1;
    checks++;
    if (field_display !== exp_fd) begin errors++; $display("FAIL rot180 got %h exp %h", field_display, exp_fd); end
    run_frame('0, 5, 5, 16'h000F, 3, lat);
    exp_fd = '0;
    for (int y = 5; y <= 8; y++) exp_fd[y*20+5] = 1'b1;
    checks++;
    if (field_display !== exp_fd) begin errors++; $display("FAIL rot270 got %h exp %h", field_display, exp_fd); end
    $display("test_rotation: rot 1/2/3 done");
  endtask

  task automatic test_edge_clip();
    int lat;
    logic [CELLS-1:0] exp_fd;
    logic exp_o;
    run_frame('0, 18, 19, 16'hFFFF, 0, lat);
    exp_fd = '0; exp_fd[398] = 1'b1; exp_fd[399] = 1'b1;
`ifdef COLLISION_EN
    exp_o = 1'b1;
`else
    exp_o = 1'b0;
`endif
    checks++;
    if (field_display !== exp_fd) begin errors++; $display("FAIL clip_frame got %h exp %h", field_display, exp_fd); end
    checks++;
    if (out_of_bounds !== exp_o || collision !== 1'b0) begin
      errors++; $display("FAIL clip_flags got oob=%b coll=%b exp oob=%b coll=0", out_of_bounds, collision, exp_o);
    end
    $display("test_edge_clip: oob=%b", out_of_bounds);
  endtask

  task automatic test_collision();
    int lat;
    logic [CELLS-1:0] lf, exp_fd;
    logic exp_c;
    lf = '0; lf[42] = 1'b1;
    run_frame(lf, 2, 2, 16'h0001, 0, lat);
`ifdef COLLISION_EN
    exp_c = 1'b1;
`else
    exp_c = 1'b0;
`endif
    checks++;
    if (field_display !== lf || collision !== exp_c) begin
      errors++; $display("FAIL collide got coll=%b frame=%h exp coll=%b frame=%h", collision, field_display, exp_c, lf);
    end
    run_frame(lf, 10, 10, 16'h0001, 0, lat);
    exp_fd = lf; exp_fd[210] = 1'b1;
    checks++;
    if (field_display !== exp_fd || collision !== 1'b0) begin
      errors++; $display("FAIL no_collide got coll=%b frame=%h exp coll=0 frame=%h", collision, field_display, exp_fd);
    end
    $display("test_collision: second frame coll=%b", collision);
  endtask

  task automatic test_handshake();
    int lat;
    logic [CELLS-1:0] lf, exp_fd, held;
    logic ec, eo;
    lf = '0; lf[0] = 1'b1; lf[399] = 1'b1;
    held = field_display;
    model(lf, 7, 2, 16'h0660, 1, exp_fd, ec, eo);
    launch(lf, 7, 2, 16'h0660, 1);
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    block_matrix = 16'hFFFF; block_pos_x = 5'd0; start = 1'b1;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    en = 1'b0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    checks++;
    if (busy !== 1'b1 || field_display !== held) begin
      errors++; $display("FAIL freeze got busy=%b frame=%h exp busy=1 frame=%h", busy, field_display, held);
    end
    en = 1'b1;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== LAT + 5) begin errors++; $display("FAIL stall_latency got %0d exp %0d", lat, LAT + 5); end
    checks++;
    if (field_display !== exp_fd) begin errors++; $display("FAIL stall_frame got %h exp %h", field_display, exp_fd); end
    $display("test_handshake: lat=%0d", lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [CELLS-1:0] exp_fd;
    logic ec, eo;
    en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b exp 1", done); end
    en = 1'b1;
    model('0, 12, 0, 16'h8421, 3, exp_fd, ec, eo);
    run_frame('0, 12, 0, 16'h8421, 3, lat);
    checks++;
    if (lat !== LAT || field_display !== exp_fd) begin
      errors++; $display("FAIL back_to_back got lat=%0d frame=%h exp lat=%0d frame=%h", lat, field_display, LAT, exp_fd);
    end
    $display("test_back_to_back: lat=%0d", lat);
  endtask

  task automatic test_random();
    int lat, px, py, rot;
    logic [CELLS-1:0] lf, exp_fd;
    logic [15:0] m;
    logic ec, eo;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < CELLS; i++) lf[i] = ($urandom_range(0, 3) == 0);
      px  = $urandom_range(0, 31);
      py  = $urandom_range(0, 31);
      if (n < 20) begin px = px % 20; py = py % 20; end
      m   = 16'($urandom);
      rot = $urandom_range(0, 3);
      model(lf, px, py, m, rot, exp_fd, ec, eo);
      run_frame(lf, px, py, m, rot, lat);
      checks++;
      if (lat !== LAT || field_display !== exp_fd || collision !== ec || out_of_bounds !== eo) begin
        errors++;
        $display("FAIL random%0d got lat=%0d coll=%b oob=%b exp lat=%0d coll=%b oob=%b frame_ok=%b",
                 n, lat, collision, out_of_bounds, LAT, ec, eo, field_display === exp_fd);
      end
      $display("random%0d: pos=(%0d,%0d) m=%h rot=%0d coll=%b oob=%b", n, px, py, m, rot, collision, out_of_bounds);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0;
    locked_field = '0; block_pos_x = '0; block_pos_y = '0; block_matrix = '0; rotate = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_latency();
    test_rotation();
    test_edge_clip();
    test_collision();
    test_handshake();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
